// File: rtl/ascon_ad_block_feeder.sv
// ascon_ad_block_feeder: sequences raw AD words into padded 64-bit rate blocks for the absorber.
module ascon_ad_block_feeder #(
  parameter int LEN_W = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] ad_len,
  input  logic             ad_word_valid,
  input  logic [63:0]      ad_word,
  output logic             ad_word_ready,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [63:0]      blk_data,
  output logic [LEN_W-1:0] blk_position,
  output logic [LEN_W-1:0] blk_len,
  output logic             blk_last,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, FETCH, EMIT, PAD, DONE} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] len, pos, rem, pos_inc;
  logic [63:0] data, padded;
  logic [5:0] sh;
  logic last, full;
  assign rem = len - pos;
  assign pos_inc = pos + LEN_W'(8);
  assign full = |rem[LEN_W-1:3];
  assign sh = {rem[2:0], 3'b000};
  // Short final word: keep rem leading bytes, drop the 0x80 marker right after them.
  assign padded = full ? ad_word : (ad_word & ~({64{1'b1}} >> sh)) | (64'h8000_0000_0000_0000 >> sh);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((ad_len == '0) ? DONE : FETCH) : IDLE;
      FETCH:   state_nx = ad_word_valid ? EMIT : FETCH;
      EMIT:    state_nx = !blk_ready ? EMIT : last ? DONE : (len == pos_inc) ? PAD : FETCH;
      PAD:     state_nx = blk_ready ? DONE : PAD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      pos   <= '0;
      data  <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        len <= ad_len;
        pos <= '0;
      end
      if (state == FETCH && ad_word_valid) begin
        data <= padded;
        last <= ~full;
      end
      if (state == EMIT && blk_ready) pos <= pos_inc;
    end
  end
  assign ad_word_ready = state == FETCH;
  assign blk_valid     = state == EMIT || state == PAD;
  assign blk_data      = (state == PAD) ? 64'h8000_0000_0000_0000 : data;
  assign blk_last      = state == PAD || (state == EMIT && last);
  assign blk_position  = pos;
  assign blk_len       = len;
  assign busy          = state != IDLE;
  assign done          = state == DONE;
endmodule

// File: tb/tb_ascon_ad_block_feeder.sv
// tb_ascon_ad_block_feeder: directed and randomized AD phases checked against a byte-level padding model.
module tb_ascon_ad_block_feeder;
  localparam int LEN_W = 33;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ad_word_valid = 1'b0, blk_ready = 1'b0;
  logic [LEN_W-1:0] ad_len = '0;
  logic [63:0] ad_word = '0;
  logic ad_word_ready, blk_valid, blk_last, busy, done;
  logic [63:0] blk_data;
  logic [LEN_W-1:0] blk_position, blk_len;
  int checks = 0, failures = 0;
  logic [63:0] words[$];

  ascon_ad_block_feeder #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ad_len(ad_len),
    .ad_word_valid(ad_word_valid), .ad_word(ad_word), .ad_word_ready(ad_word_ready),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_position(blk_position), .blk_len(blk_len), .blk_last(blk_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Block k covers message bytes 8k..8k+7: real bytes, then one 0x80, then zeros.
  function automatic logic [63:0] model_blk(input int k, input int len);
    logic [63:0] r = '0;
    logic [63:0] w;
    for (int i = 0; i < 8; i++) begin
      int idx = 8 * k + i;
      if (idx < len) begin
        w = words[k];
        r[63 - 8 * i -: 8] = w[63 - 8 * i -: 8];
      end else if (idx == len) r[63 - 8 * i -: 8] = 8'h80;
    end
    return r;
  endfunction

  task automatic run_phase(input int len, input int pct, input int stall);
    int nblk = (len == 0) ? 0 : len / 8 + 1;
    int nwords = (len + 7) / 8;
    int bi = 0, wi = 0, cyc = 0, sc = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [63:0] pd = '0, pp = '0;
    start = 1'b1;
    ad_len = LEN_W'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("blk_len", 64'(blk_len), 64'(len));
    while (!done && cyc < 2000) begin
      if (pv && !pr) begin
        chk("stall_valid", 64'(blk_valid), 64'd1);
        chk("stall_data", blk_data, pd);
        chk("stall_pos", 64'(blk_position), pp);
        chk("stall_last", 64'(blk_last), 64'(pl));
      end
      if (blk_valid) chk("word_ready_while_blk", 64'(ad_word_ready), 64'd0);
      sc = blk_valid ? sc + 1 : 0;
      blk_ready = (stall > 0) ? (sc > stall) : ($urandom_range(99) < pct);
      ad_word_valid = 1'($urandom_range(1));
      ad_word = (wi < nwords) ? words[wi] : {$urandom, $urandom};
      if (blk_valid && blk_ready) begin
        if (bi < nblk) begin
          chk("blk_data", blk_data, model_blk(bi, len));
          chk("blk_pos", 64'(blk_position), 64'(8 * bi));
          chk("blk_last", 64'(blk_last), 64'(bi == nblk - 1));
        end else chk("extra_block", 64'd1, 64'd0);
        bi++;
        sc = 0;
      end
      if (ad_word_valid && ad_word_ready) wi++;
      pv = blk_valid;
      pr = blk_ready;
      pd = blk_data;
      pp = 64'(blk_position);
      pl = blk_last;
      @(posedge clk);
      #1;
      cyc++;
    end
    blk_ready = 1'b0;
    ad_word_valid = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("block_count", 64'(bi), 64'(nblk));
    chk("words_consumed", 64'(wi), 64'(nwords));
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {59'd0, blk_valid, blk_last, busy, done, ad_word_ready}, 64'd0);
    chk("reset_data", blk_data, 64'd0);
    chk("reset_pos", 64'(blk_position), 64'd0);
    chk("reset_len", 64'(blk_len), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    words = {64'h4153434F4E656E63, 64'h4153434F4E656E63, 64'h4153434F4E656E63};
    run_phase(20, 100, 0);
    run_phase(16, 100, 0);
    run_phase(0, 100, 0);
    run_phase(20, 0, 3);
    words = {64'hFFFF_FFFF_FFFF_FFFF};
    run_phase(1, 100, 0);
    // Reset while the second block is on the bus, then replay the first scenario.
    words = {64'h4153434F4E656E63, 64'h4153434F4E656E63, 64'h4153434F4E656E63};
    start = 1'b1;
    ad_len = LEN_W'(20);
    @(posedge clk);
    #1;
    start = 1'b0;
    ad_word_valid = 1'b1;
    ad_word = words[0];
    blk_ready = 1'b1;
    cyc = 0;
    while (!(blk_valid && blk_position == LEN_W'(8)) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reach_second_emit", 64'(blk_valid && blk_position == LEN_W'(8)), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {59'd0, blk_valid, blk_last, busy, done, ad_word_ready}, 64'd0);
    chk("async_reset_data", blk_data, 64'd0);
    chk("async_reset_pos", 64'(blk_position), 64'd0);
    chk("async_reset_len", 64'(blk_len), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_done_in_reset", 64'(done), 64'd0);
    end
    ad_word_valid = 1'b0;
    blk_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_phase(20, 100, 0);
    for (int n = 0; n < 25; n++) begin
      words = {};
      for (int i = 0; i < 7; i++) words.push_back({$urandom, $urandom});
      run_phase(int'($urandom_range(45)), int'($urandom_range(100, 20)), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
